lot_occupancy_ctrl: RTL and testbench

- Central occupancy controller for a multi-lane parking facility.
- Merges the single-cycle inc/dec pulses from NUM_LANES per-lane car detectors into one shared occupancy counter.
- Saturates the counter at CAPACITY and at 0, and flags any overflow or underflow.
- Runs an OPEN/CLOSED admission state machine with hysteresis that drives the entry-permit signals back to every lane's gate.

---
 rtl/lot_pkg.sv | 15 +
 rtl/lot_popcount.sv | 20 ++
 rtl/lot_occupancy_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lot_occupancy_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lot_pkg.sv
// Shared definitions for the parking-lot occupancy controller:
// admission FSM state encoding and the default facility dimensions.
package lot_pkg;

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_CLOSED = 1'b1
   } lot_state_t;

   localparam int LOT_CAPACITY  = 64;
   localparam int LOT_NUM_LANES = 2;
   localparam int LOT_CNT_W     = 7;
   localparam int LOT_HYST      = 4;

endpackage

// File: rtl/lot_popcount.sv
// Combinational population count of a per-lane pulse vector.
module lot_popcount
   import lot_pkg::*;
#(
   parameter int NUM_LANES = LOT_NUM_LANES,
   parameter int POP_W     = $clog2(NUM_LANES + 1)
) (
   input  logic [NUM_LANES-1:0] vec,
   output logic [POP_W-1:0]     pop
);

   // Sum the set bits of the lane vector.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         pop = pop + POP_W'(vec[i]);
      end
   end

endmodule

// File: rtl/lot_occupancy_ctrl.sv
// Central occupancy controller: merges per-lane inc/dec pulses into one
// saturating occupancy counter, keeps sticky clamp flags and runs the
// OPEN/CLOSED admission FSM that drives lane_allow.
// Optional statistics outputs (total_in, peak_count) are built when the
// macro LOT_OCCUPANCY_STATS_EN is defined.
module lot_occupancy_ctrl
   import lot_pkg::*;
#(
   parameter int NUM_LANES   = LOT_NUM_LANES,
   parameter int CAPACITY    = LOT_CAPACITY,
   parameter int CNT_W       = LOT_CNT_W,
   parameter int REOPEN_HYST = LOT_HYST
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_LANES-1:0] inc,
   input  logic [NUM_LANES-1:0] dec,
   input  logic                 load,
   input  logic [CNT_W-1:0]     load_val,
   input  logic                 clear_err,
   output logic [CNT_W-1:0]     count,
   output logic                 full,
   output logic                 empty,
   output logic [NUM_LANES-1:0] lane_allow,
   output logic                 err_overflow,
   output logic                 err_underflow
`ifdef LOT_OCCUPANCY_STATS_EN
   ,
   output logic [31:0]          total_in,
   output logic [CNT_W-1:0]     peak_count
`endif
);

   localparam int POP_W = $clog2(NUM_LANES + 1);
   localparam int SUM_W = CNT_W + 2;

   localparam logic signed [SUM_W-1:0] CAP_S    = SUM_W'(CAPACITY);
   localparam logic        [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
   localparam logic        [CNT_W-1:0] REOPEN_C = CNT_W'(CAPACITY - REOPEN_HYST);

   // A lane pulsing inc and dec together nets to zero, so mask both sides.
   logic [NUM_LANES-1:0]    inc_acc;
   logic [NUM_LANES-1:0]    dec_acc;
   logic [POP_W-1:0]        pop_in;
   logic [POP_W-1:0]        pop_out;
   logic signed [SUM_W-1:0] net;
   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] target;
   logic [CNT_W-1:0]        count_next;
   logic                    ovf_evt;
   logic                    udf_evt;
   lot_state_t              state;
   lot_state_t              state_next;

   // Clamp a signed candidate occupancy into 0..CAPACITY.
   function automatic logic [CNT_W-1:0] sat_count(input logic signed [SUM_W-1:0] s);
      if (s[SUM_W-1]) begin
         return '0;
      end else if (s > CAP_S) begin
         return CAP_C;
      end else begin
         return s[CNT_W-1:0];
      end
   endfunction

   lot_popcount #(.NUM_LANES(NUM_LANES), .POP_W(POP_W)) u_pop_inc (
      .vec (inc_acc),
      .pop (pop_in)
   );

   lot_popcount #(.NUM_LANES(NUM_LANES), .POP_W(POP_W)) u_pop_dec (
      .vec (dec_acc),
      .pop (pop_out)
   );

   // Next-count datapath: net event sum, load override, clamp and error events.
   always_comb begin
      inc_acc    = inc & ~dec;
      dec_acc    = dec & ~inc;
      net        = $signed(SUM_W'(pop_in)) - $signed(SUM_W'(pop_out));
      sum        = $signed({2'b00, count}) + net;
      target     = load ? $signed({2'b00, load_val}) : sum;
      count_next = sat_count(target);
      ovf_evt    = !target[SUM_W-1] && (target > CAP_S);
      udf_evt    = target[SUM_W-1];
   end

   // Occupancy register with flags derived from the next value.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         count <= count_next;
         full  <= (count_next == CAP_C);
         empty <= (count_next == '0);
      end
   end

   // Sticky clamp flags; a fresh clamp outranks clear_err in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         err_overflow  <= ovf_evt | (err_overflow  & ~clear_err);
         err_underflow <= udf_evt | (err_underflow & ~clear_err);
      end
   end

   // Admission FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_OPEN;
      end else begin
         state <= state_next;
      end
   end

   // Admission FSM transitions (judged on next count, so lane_allow moves
   // with count) and lane permit decode.
   always_comb begin
      state_next = state;
      lane_allow = '0;
      case (state)
         ST_OPEN: begin
            lane_allow = '1;
            if (count_next == CAP_C) begin
               state_next = ST_CLOSED;
            end
         end
         ST_CLOSED: begin
            if (count_next <= REOPEN_C) begin
               state_next = ST_OPEN;
            end
         end
         default: begin
            state_next = ST_OPEN;
         end
      endcase
   end

`ifdef LOT_OCCUPANCY_STATS_EN
   // Statistics: accepted entries (not counted when load discards events)
   // and the high-water mark of occupancy, which load does not reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         total_in   <= '0;
         peak_count <= '0;
      end else begin
         if (!load) begin
            total_in <= total_in + 32'(pop_in);
         end
         if (count_next > peak_count) begin
            peak_count <= count_next;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lot_occupancy_ctrl.sv
// Directed bench for lot_occupancy_ctrl (NUM_LANES=2, CAPACITY=64,
// REOPEN_HYST=4): a one-vector-per-cycle table plus hand sequences for
// pulse latency and reset in the middle of a burst.
module tb_lot_occupancy_ctrl;

   localparam int NL = 2;
   localparam int CW = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic [NL-1:0] inc;
   logic [NL-1:0] dec;
   logic          load;
   logic [CW-1:0] load_val;
   logic          clear_err;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic [NL-1:0] lane_allow;
   logic          err_overflow;
   logic          err_underflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          rst;
      logic [NL-1:0] inc;
      logic [NL-1:0] dec;
      logic          ld;
      logic [CW-1:0] ld_val;
      logic          clr;
      logic [CW-1:0] e_count;
      logic          e_full;
      logic          e_empty;
      logic [NL-1:0] e_allow;
      logic          e_ovf;
      logic          e_udf;
   } vec_t;

   vec_t vecs[$];

   lot_occupancy_ctrl #(
      .NUM_LANES   (NL),
      .CAPACITY    (64),
      .CNT_W       (CW),
      .REOPEN_HYST (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .inc           (inc),
      .dec           (dec),
      .load          (load),
      .load_val      (load_val),
      .clear_err     (clear_err),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .lane_allow    (lane_allow),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [NL-1:0] i, input logic [NL-1:0] d,
                      input logic ld, input int lv, input logic clr,
                      input int c, input logic f, input logic e,
                      input logic [NL-1:0] a, input logic ov, input logic ud);
      vec_t v;
      v.rst = rst; v.inc = i; v.dec = d; v.ld = ld; v.ld_val = CW'(lv); v.clr = clr;
      v.e_count = CW'(c); v.e_full = f; v.e_empty = e; v.e_allow = a;
      v.e_ovf = ov; v.e_udf = ud;
      vecs.push_back(v);
   endtask

   task automatic drive_idle();
      reset = 1'b0; inc = '0; dec = '0; load = 1'b0; load_val = '0; clear_err = 1'b0;
   endtask

   task automatic check_all(input string tag, input int c, input logic f, input logic e,
                            input logic [NL-1:0] a, input logic ov, input logic ud);
      chk({tag, " count"}, int'(count), c);
      chk({tag, " full"}, int'(full), int'(f));
      chk({tag, " empty"}, int'(empty), int'(e));
      chk({tag, " lane_allow"}, int'(lane_allow), int'(a));
      chk({tag, " err_overflow"}, int'(err_overflow), int'(ov));
      chk({tag, " err_underflow"}, int'(err_underflow), int'(ud));
   endtask

   initial begin
      //   rst inc    dec    ld lv  clr  count f e allow  ov ud
      add(1, 2'b00, 2'b00, 0, 0,  0,   0,  0, 1, 2'b11, 0, 0); // 0 reset
      add(0, 2'b00, 2'b00, 0, 0,  0,   0,  0, 1, 2'b11, 0, 0); // 1 idle
      add(0, 2'b01, 2'b00, 0, 0,  0,   1,  0, 0, 2'b11, 0, 0); // 2 inc lane0
      add(0, 2'b00, 2'b00, 1, 10, 0,  10,  0, 0, 2'b11, 0, 0); // 3 load 10
      add(0, 2'b11, 2'b10, 0, 0,  0,  11,  0, 0, 2'b11, 0, 0); // 4 lane1 cancels
      add(0, 2'b00, 2'b00, 1, 63, 0,  63,  0, 0, 2'b11, 0, 0); // 5 load 63
      add(0, 2'b11, 2'b00, 0, 0,  0,  64,  1, 0, 2'b00, 1, 0); // 6 65 -> clamp
      add(0, 2'b00, 2'b01, 0, 0,  0,  63,  0, 0, 2'b00, 1, 0); // 7
      add(0, 2'b00, 2'b01, 0, 0,  0,  62,  0, 0, 2'b00, 1, 0); // 8
      add(0, 2'b00, 2'b01, 0, 0,  0,  61,  0, 0, 2'b00, 1, 0); // 9 still closed
      add(0, 2'b00, 2'b01, 0, 0,  0,  60,  0, 0, 2'b11, 1, 0); // 10 reopen
      add(0, 2'b00, 2'b00, 0, 0,  1,  60,  0, 0, 2'b11, 0, 0); // 11 clear
      add(0, 2'b00, 2'b00, 1, 0,  0,   0,  0, 1, 2'b11, 0, 0); // 12 load 0
      add(0, 2'b00, 2'b10, 0, 0,  0,   0,  0, 1, 2'b11, 0, 1); // 13 underflow
      add(0, 2'b00, 2'b01, 0, 0,  1,   0,  0, 1, 2'b11, 0, 1); // 14 new err wins
      add(0, 2'b00, 2'b00, 0, 0,  1,   0,  0, 1, 2'b11, 0, 0); // 15 clear alone
      add(0, 2'b11, 2'b00, 1, 70, 0,  64,  1, 0, 2'b00, 1, 0); // 16 load 70 + inc
      add(0, 2'b11, 2'b11, 0, 0,  0,  64,  1, 0, 2'b00, 1, 0); // 17 all cancel
      add(0, 2'b00, 2'b00, 1, 5,  0,   5,  0, 0, 2'b11, 1, 0); // 18 load reopens
      add(0, 2'b11, 2'b00, 0, 0,  0,   7,  0, 0, 2'b11, 1, 0); // 19 +2
      add(1, 2'b11, 2'b00, 0, 0,  0,   0,  0, 1, 2'b11, 0, 0); // 20 reset wins
      add(0, 2'b10, 2'b00, 0, 0,  0,   1,  0, 0, 2'b11, 0, 0); // 21 inc lane1
      add(0, 2'b00, 2'b00, 1, 64, 0,  64,  1, 0, 2'b00, 0, 0); // 22 load full
      add(0, 2'b00, 2'b00, 1, 61, 0,  61,  0, 0, 2'b00, 0, 0); // 23 load 61 closed
      add(0, 2'b00, 2'b00, 1, 60, 0,  60,  0, 0, 2'b11, 0, 0); // 24 load 60 open
      add(0, 2'b00, 2'b00, 1, 70, 1,  64,  1, 0, 2'b00, 1, 0); // 25 clear vs ovf

      drive_idle();
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[k]) begin
         reset = vecs[k].rst; inc = vecs[k].inc; dec = vecs[k].dec;
         load = vecs[k].ld; load_val = vecs[k].ld_val; clear_err = vecs[k].clr;
         @(negedge clk);
         check_all($sformatf("vec%0d", k), int'(vecs[k].e_count), vecs[k].e_full,
                   vecs[k].e_empty, vecs[k].e_allow, vecs[k].e_ovf, vecs[k].e_udf);
      end

      // Latency: a pulse shows up on count exactly one edge later.
      drive_idle();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      inc = 2'b01;
      #1;
      chk("lat pre count", int'(count), 0);
      chk("lat pre empty", int'(empty), 1);
      @(posedge clk);
      #1;
      inc = 2'b00;
      chk("lat post count", int'(count), 1);
      chk("lat post empty", int'(empty), 0);

      // Burst of entries interrupted by reset.
      @(negedge clk);
      inc = 2'b11;
      repeat (3) @(negedge clk);
      chk("burst count", int'(count), 7);
      reset = 1'b1;
      @(negedge clk);
      chk("burst reset count", int'(count), 0);
      chk("burst reset allow", int'(lane_allow), 3);
      chk("burst reset empty", int'(empty), 1);
      reset = 1'b0;
      @(negedge clk);
      chk("burst resume count", int'(count), 2);
      drive_idle();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
